// File: rtl/ex_muldiv_unit.sv
// Multi-cycle shift-add multiplier / restoring divider with architectural HI/LO.
// Define MULDIV_SIGNED_EN to honour In_Op[0] (signed MULT/DIV) via an extra FIXUP cycle.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             In_Start,
    input  logic [1:0]       In_Op,
    input  logic [WIDTH-1:0] In_OperandA,
    input  logic [WIDTH-1:0] In_OperandB,
    input  logic             In_WriteHi,
    input  logic             In_WriteLo,
    input  logic [WIDTH-1:0] In_MoveData,
    output logic [WIDTH-1:0] Out_Hi,
    output logic [WIDTH-1:0] Out_Lo,
    output logic             Out_Busy,
    output logic             Out_Done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } state_t;

    state_t               state;
    state_t               stateNext;
    logic [CW-1:0]        count;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   accStep;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     remStep;
    logic [WIDTH:0]       shifted;
    logic [WIDTH:0]       addSum;
    logic [WIDTH-1:0]     opA;
    logic [WIDTH-1:0]     opB;
    logic [WIDTH-1:0]     rawA;
    logic                 isDiv;
    logic                 divZero;
    logic                 finish;
    logic [WIDTH-1:0]     magA;
    logic [WIDTH-1:0]     magB;
    logic                 startSignA;
    logic                 startSignB;
    logic [2*WIDTH-1:0]   resAcc;
    logic [WIDTH-1:0]     resRem;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic [WIDTH-1:0]     resHi;
    logic [WIDTH-1:0]     resLo;
    logic [WIDTH-1:0]     hiReg;
    logic [WIDTH-1:0]     loReg;
    logic                 doneReg;

`ifdef MULDIV_SIGNED_EN
    logic                 signA;
    logic                 signB;
    // Result is corrected from the settled accumulator in the FIXUP cycle
    assign resAcc = acc;
    assign resRem = rem;
`else
    logic                 unusedOpSign;
    assign unusedOpSign = In_Op[0];
    // Without FIXUP the last CALC iteration commits its own output directly
    assign resAcc = accStep;
    assign resRem = remStep;
`endif

    assign Out_Hi   = hiReg;
    assign Out_Lo   = loReg;
    assign Out_Done = doneReg;
    assign Out_Busy = (state != IDLE);

    // Operand magnitudes and sign flags presented at launch
    always_comb begin
`ifdef MULDIV_SIGNED_EN
        startSignA = In_Op[0] & In_OperandA[WIDTH-1];
        startSignB = In_Op[0] & In_OperandB[WIDTH-1];
`else
        startSignA = 1'b0;
        startSignB = 1'b0;
`endif
        if (startSignA) begin
            magA = -In_OperandA;
        end else begin
            magA = In_OperandA;
        end
        if (startSignB) begin
            magB = -In_OperandB;
        end else begin
            magB = In_OperandB;
        end
    end

    // One shift-add or restoring-divide iteration
    always_comb begin
        accStep = acc;
        remStep = rem;
        shifted = {rem, acc[WIDTH-1]};
        addSum  = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (isDiv) begin
            if (shifted >= {1'b0, opB}) begin
                remStep = shifted[WIDTH-1:0] - opB;
                accStep = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b1};
            end else begin
                remStep = shifted[WIDTH-1:0];
                accStep = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc[0]) begin
                addSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opA};
            end else begin
                addSum = {1'b0, acc[2*WIDTH-1:WIDTH]};
            end
            accStep = {addSum, acc[WIDTH-1:1]};
        end
    end

    // Sign correction and HI/LO placement of the finished operation
    always_comb begin
        product   = resAcc;
        quotient  = resAcc[WIDTH-1:0];
        remainder = resRem;
`ifdef MULDIV_SIGNED_EN
        if (signA ^ signB) begin
            product  = -resAcc;
            quotient = -resAcc[WIDTH-1:0];
        end else begin
            product  = resAcc;
            quotient = resAcc[WIDTH-1:0];
        end
        if (signA) begin
            remainder = -resRem;
        end else begin
            remainder = resRem;
        end
`endif
        if (!isDiv) begin
            resHi = product[2*WIDTH-1:WIDTH];
            resLo = product[WIDTH-1:0];
        end else if (divZero) begin
            resHi = rawA;
            resLo = {WIDTH{1'b1}};
        end else begin
            resHi = remainder;
            resLo = quotient;
        end
    end

    // Next-state and completion decode
    always_comb begin
        stateNext = state;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (In_Start) begin
                    stateNext = CALC;
                end else begin
                    stateNext = IDLE;
                end
            end
            CALC: begin
                if (count == CW'(WIDTH - 1)) begin
`ifdef MULDIV_SIGNED_EN
                    stateNext = FIXUP;
`else
                    stateNext = IDLE;
                    finish    = 1'b1;
`endif
                end else begin
                    stateNext = CALC;
                end
            end
            FIXUP: begin
                stateNext = IDLE;
                finish    = 1'b1;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State, datapath and HI/LO registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            count   <= {CW{1'b0}};
            acc     <= {(2*WIDTH){1'b0}};
            rem     <= {WIDTH{1'b0}};
            opA     <= {WIDTH{1'b0}};
            opB     <= {WIDTH{1'b0}};
            rawA    <= {WIDTH{1'b0}};
            isDiv   <= 1'b0;
            divZero <= 1'b0;
            hiReg   <= {WIDTH{1'b0}};
            loReg   <= {WIDTH{1'b0}};
            doneReg <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            signA   <= 1'b0;
            signB   <= 1'b0;
`endif
        end else begin
            state   <= stateNext;
            doneReg <= finish;
            case (state)
                IDLE: begin
                    if (In_WriteHi) hiReg <= In_MoveData;
                    if (In_WriteLo) loReg <= In_MoveData;
                    if (In_Start) begin
                        opA     <= magA;
                        opB     <= magB;
                        rawA    <= In_OperandA;
                        isDiv   <= In_Op[1];
                        divZero <= In_Op[1] & (In_OperandB == {WIDTH{1'b0}});
                        rem     <= {WIDTH{1'b0}};
                        count   <= {CW{1'b0}};
                        // Low half carries the multiplier or the dividend being shifted out
                        acc     <= {{WIDTH{1'b0}}, (In_Op[1] ? magA : magB)};
`ifdef MULDIV_SIGNED_EN
                        signA   <= startSignA;
                        signB   <= startSignB;
`endif
                    end
                end
                CALC: begin
                    acc   <= accStep;
                    rem   <= remStep;
                    count <= count + CW'(1);
                end
                FIXUP: begin
                    count <= {CW{1'b0}};
                end
                default: begin
                    count <= {CW{1'b0}};
                end
            endcase
            if (finish) begin
                hiReg <= resHi;
                loReg <= resLo;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed and random ops against an arithmetic model.
module tb_ex_muldiv_unit;

`ifdef MULDIV_SIGNED_EN
    localparam bit SignedEn = 1'b1;
    localparam int Lat      = 33;
`else
    localparam bit SignedEn = 1'b0;
    localparam int Lat      = 32;
`endif

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        In_Start = 1'b0;
    logic [1:0]  In_Op = 2'd0;
    logic [31:0] In_OperandA = 32'd0;
    logic [31:0] In_OperandB = 32'd0;
    logic        In_WriteHi = 1'b0;
    logic        In_WriteLo = 1'b0;
    logic [31:0] In_MoveData = 32'd0;
    logic [31:0] Out_Hi;
    logic [31:0] Out_Lo;
    logic        Out_Busy;
    logic        Out_Done;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expHi;
    logic [31:0] expLo;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .Clock(Clock), .Reset(Reset), .In_Start(In_Start), .In_Op(In_Op),
        .In_OperandA(In_OperandA), .In_OperandB(In_OperandB),
        .In_WriteHi(In_WriteHi), .In_WriteLo(In_WriteLo), .In_MoveData(In_MoveData),
        .Out_Hi(Out_Hi), .Out_Lo(Out_Lo), .Out_Busy(Out_Busy), .Out_Done(Out_Done)
    );

    always #5 Clock = ~Clock;

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        longint sa, sb;
        logic [31:0] q, r;
        sgn = op[0] && SignedEn;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op[1]) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (sgn) begin
                q = 32'(sa / sb);
                r = 32'(sa % sb);
            end else begin
                q = a / b;
                r = a % b;
            end
            return {r, q};
        end
        if (sgn) return 64'(sa * sb);
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        {expHi, expLo} = model(op, a, b);
        In_Op = op; In_OperandA = a; In_OperandB = b; In_Start = 1'b1;
        @(posedge Clock); #1;
        In_Start = 1'b0; In_WriteHi = 1'b0; In_WriteLo = 1'b0;
    endtask

    task automatic wait_result(input string name, input int pulseAt);
        logic [31:0] prevHi, prevLo;
        int edges;
        prevHi = Out_Hi; prevLo = Out_Lo; edges = 0;
        while (Out_Done !== 1'b1 && edges < 100) begin
            checks++;
            if (Out_Busy !== 1'b1) begin
                errors++; $display("FAIL %s busy: got %b expected 1 at cycle %0d", name, Out_Busy, edges);
            end
            checks++;
            if (Out_Hi !== prevHi || Out_Lo !== prevLo) begin
                errors++; $display("FAIL %s hold: got %h_%h expected %h_%h at cycle %0d", name, Out_Hi, Out_Lo, prevHi, prevLo, edges);
            end
            if (edges == pulseAt) begin
                In_Start = 1'b1; In_Op = ~In_Op; In_OperandA = $urandom; In_OperandB = $urandom;
                In_WriteHi = 1'b1; In_WriteLo = 1'b1; In_MoveData = $urandom;
            end
            @(posedge Clock); #1;
            In_Start = 1'b0; In_WriteHi = 1'b0; In_WriteLo = 1'b0;
            edges++;
        end
        checks++;
        if (edges != Lat) begin
            errors++; $display("FAIL %s latency: got %0d expected %0d", name, edges, Lat);
        end
        checks++;
        if (Out_Busy !== 1'b0) begin
            errors++; $display("FAIL %s busy_in_done: got %b expected 0", name, Out_Busy);
        end
        checks++;
        if (Out_Hi !== expHi) begin
            errors++; $display("FAIL %s hi: got %h expected %h", name, Out_Hi, expHi);
        end
        checks++;
        if (Out_Lo !== expLo) begin
            errors++; $display("FAIL %s lo: got %h expected %h", name, Out_Lo, expLo);
        end
    endtask

    task automatic test_reset();
        @(negedge Clock); Reset = 1'b1;
        repeat (2) @(posedge Clock); #1;
        checks++;
        if (Out_Hi !== 32'd0 || Out_Lo !== 32'd0) begin
            errors++; $display("FAIL reset hilo: got %h_%h expected 0_0", Out_Hi, Out_Lo);
        end
        checks++;
        if (Out_Busy !== 1'b0 || Out_Done !== 1'b0) begin
            errors++; $display("FAIL reset flags: got busy=%b done=%b expected 0 0", Out_Busy, Out_Done);
        end
        Reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [1:0]  ops [7] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd3, 2'd3};
        logic [31:0] as  [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'd5, 32'h8000_0000, 32'hFFFF_FFF8};
        logic [31:0] bs  [7] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd0};
        for (int i = 0; i < 7; i++) begin
            @(negedge Clock);
            start_op(ops[i], as[i], bs[i]);
            wait_result($sformatf("directed%0d", i), -1);
        end
    endtask

    task automatic test_move();
        @(negedge Clock); In_WriteLo = 1'b1; In_MoveData = 32'h0000_1234;
        @(posedge Clock); #1; In_WriteLo = 1'b0;
        checks++;
        if (Out_Lo !== 32'h0000_1234) begin
            errors++; $display("FAIL mtlo: got %h expected 00001234", Out_Lo);
        end
        @(negedge Clock); In_WriteHi = 1'b1; In_MoveData = 32'h0000_AAAA;
        start_op(2'd0, 32'd2, 32'd3);
        checks++;
        if (Out_Hi !== 32'h0000_AAAA) begin
            errors++; $display("FAIL mthi_with_start: got %h expected 0000aaaa", Out_Hi);
        end
        wait_result("mthi_then_multu", -1);
    endtask

    task automatic test_abort();
        int doneSeen;
        @(negedge Clock); In_WriteHi = 1'b1; In_WriteLo = 1'b1; In_MoveData = 32'h5555_0000;
        start_op(2'd0, 32'd3, 32'd4);
        repeat (10) @(posedge Clock); #1;
        Reset = 1'b1;
        @(posedge Clock); #1; Reset = 1'b0;
        checks++;
        if (Out_Busy !== 1'b0 || Out_Hi !== 32'd0 || Out_Lo !== 32'd0) begin
            errors++; $display("FAIL abort: got busy=%b hi=%h lo=%h expected 0 0 0", Out_Busy, Out_Hi, Out_Lo);
        end
        doneSeen = 0;
        repeat (40) begin
            @(posedge Clock); #1;
            if (Out_Done === 1'b1 || Out_Busy === 1'b1) doneSeen++;
        end
        checks++;
        if (doneSeen != 0) begin
            errors++; $display("FAIL abort_quiet: got %0d active cycles expected 0", doneSeen);
        end
    endtask

    task automatic test_ignore();
        @(negedge Clock);
        start_op(2'd0, 32'h0001_2345, 32'h0000_0777);
        wait_result("ignore_start_mt", 5);
        @(negedge Clock);
        start_op(2'd2, 32'hDEAD_BEEF, 32'd13);
        wait_result("ignore_div", 20);
    endtask

    task automatic test_back_to_back();
        @(negedge Clock);
        start_op(2'd0, 32'd123456, 32'd789);
        wait_result("b2b_first", -1);
        start_op(2'd3, 32'hFFFF_FF00, 32'd9);
        wait_result("b2b_second", -1);
        start_op(2'd1, 32'h8000_0000, 32'h8000_0000);
        wait_result("b2b_third", -1);
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 5) == 0) a = a & 32'h0000_FFFF;
            @(negedge Clock);
            start_op(op, a, b);
            wait_result($sformatf("random%0d_op%0d", i, op), (i % 3 == 0) ? int'($urandom_range(0, 30)) : -1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_move();
        test_abort();
        test_ignore();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
